// File: rtl/execute_flag_ckpt_register_if.sv
// execute_flag_ckpt_register_if: flag/checkpoint bus; oSRC_CONFLICT present only with EXECUTE_FLAG_CKPT_SRC_CHECK_EN.
interface execute_flag_ckpt_register_if #(
  parameter int P_FLAG_W     = 5,
  parameter int P_NSRC       = 4,
  parameter int P_CKPT_DEPTH = 4,
  parameter int P_CNT_W      = $clog2(P_CKPT_DEPTH + 1)
);
  logic                       iRESET_SYNC;
  logic                       iCTRL_HOLD;
  logic                       iPFLAGR_VALID;
  logic [P_FLAG_W-1:0]        iPFLAGR;
  logic                       iPREV_INST_VALID;
  logic                       iPREV_BUSY;
  logic                       iPREV_FLAG_WRITE;
  logic [P_NSRC-1:0]          iSRC_VALID;
  logic [P_NSRC*P_FLAG_W-1:0] iSRC_FLAG;
  logic                       iCKPT_PUSH;
  logic                       iCKPT_RELEASE;
  logic                       iCKPT_RESTORE;
  logic [P_FLAG_W-1:0]        oFLAG;
  logic [P_CNT_W-1:0]         oCKPT_COUNT;
  logic                       oCKPT_FULL;
  logic                       oCKPT_EMPTY;
  logic                       oCKPT_OVF;
`ifdef EXECUTE_FLAG_CKPT_SRC_CHECK_EN
  logic                       oSRC_CONFLICT;
`endif
  modport master (
    output iRESET_SYNC, iCTRL_HOLD, iPFLAGR_VALID, iPFLAGR, iPREV_INST_VALID, iPREV_BUSY,
           iPREV_FLAG_WRITE, iSRC_VALID, iSRC_FLAG, iCKPT_PUSH, iCKPT_RELEASE, iCKPT_RESTORE,
    input  oFLAG, oCKPT_COUNT, oCKPT_FULL, oCKPT_EMPTY, oCKPT_OVF
`ifdef EXECUTE_FLAG_CKPT_SRC_CHECK_EN
    , input oSRC_CONFLICT
`endif
  );
  modport slave (
    input  iRESET_SYNC, iCTRL_HOLD, iPFLAGR_VALID, iPFLAGR, iPREV_INST_VALID, iPREV_BUSY,
           iPREV_FLAG_WRITE, iSRC_VALID, iSRC_FLAG, iCKPT_PUSH, iCKPT_RELEASE, iCKPT_RESTORE,
    output oFLAG, oCKPT_COUNT, oCKPT_FULL, oCKPT_EMPTY, oCKPT_OVF
`ifdef EXECUTE_FLAG_CKPT_SRC_CHECK_EN
    , output oSRC_CONFLICT
`endif
  );
endinterface

// File: rtl/execute_flag_ckpt_register.sv
// execute_flag_ckpt_register: execute-stage flag register with in-order checkpoint FIFO for mispredict restore.
// Optional EXECUTE_FLAG_CKPT_SRC_CHECK_EN adds a registered multi-source conflict pulse.
module execute_flag_ckpt_register #(
  parameter int P_FLAG_W     = 5,
  parameter int P_NSRC       = 4,
  parameter int P_CKPT_DEPTH = 4,
  parameter int P_CNT_W      = $clog2(P_CKPT_DEPTH + 1)
) (
  input logic iCLOCK,
  input logic inRESET,
  execute_flag_ckpt_register_if.slave bus
);
  localparam int PW = P_CKPT_DEPTH > 1 ? $clog2(P_CKPT_DEPTH) : 1;
  logic [P_FLAG_W-1:0] flag_q, flag_d, sel_flag;
  logic [P_FLAG_W-1:0] mem_q [P_CKPT_DEPTH];
  logic [P_CNT_W-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic                ovf_q, ovf_d, restore, act, rel, push, upd_ok;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(P_CKPT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    sel_flag = '0;
    for (int i = P_NSRC - 1; i >= 0; i--)
      if (bus.iSRC_VALID[i]) sel_flag = bus.iSRC_FLAG[i*P_FLAG_W +: P_FLAG_W];
  end
  assign restore = bus.iCKPT_RESTORE && cnt_q != '0;
  assign act     = !bus.iCTRL_HOLD && !restore;
  assign upd_ok  = act && !bus.iPFLAGR_VALID && bus.iPREV_INST_VALID && !bus.iPREV_BUSY && bus.iPREV_FLAG_WRITE;
  assign rel     = act && bus.iCKPT_RELEASE && cnt_q != '0;
  // a release in the same cycle frees the slot a full-FIFO push needs
  assign push    = act && bus.iCKPT_PUSH && (cnt_q != P_CNT_W'(P_CKPT_DEPTH) || rel);
  always_comb begin
    flag_d = restore ? mem_q[rptr_q] : bus.iPFLAGR_VALID ? bus.iPFLAGR :
             (upd_ok && |bus.iSRC_VALID) ? sel_flag : flag_q;
    cnt_d  = restore ? '0 : cnt_q + P_CNT_W'(push) - P_CNT_W'(rel);
    rptr_d = rel ? inc(rptr_q) : rptr_q;
    wptr_d = restore ? rptr_q : push ? inc(wptr_q) : wptr_q;
    ovf_d  = ovf_q || (act && bus.iCKPT_PUSH && !push);
  end
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      flag_q <= '0;
      cnt_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
      for (int i = 0; i < P_CKPT_DEPTH; i++) mem_q[i] <= '0;
    end else if (bus.iRESET_SYNC) begin
      flag_q <= '0;
      cnt_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
      for (int i = 0; i < P_CKPT_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      flag_q <= flag_d;
      cnt_q  <= cnt_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
      if (push) mem_q[wptr_q] <= flag_d;
    end
  end
  assign bus.oFLAG       = flag_q;
  assign bus.oCKPT_COUNT = cnt_q;
  assign bus.oCKPT_FULL  = cnt_q == P_CNT_W'(P_CKPT_DEPTH);
  assign bus.oCKPT_EMPTY = cnt_q == '0;
  assign bus.oCKPT_OVF   = ovf_q;
`ifdef EXECUTE_FLAG_CKPT_SRC_CHECK_EN
  logic conf_q;
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) conf_q <= 1'b0;
    else conf_q <= !bus.iRESET_SYNC && upd_ok && ((bus.iSRC_VALID & (bus.iSRC_VALID - 1'b1)) != '0);
  end
  assign bus.oSRC_CONFLICT = conf_q;
`endif
endmodule

// File: tb/tb_execute_flag_ckpt_register.sv
// tb_execute_flag_ckpt_register: directed scenarios plus random traffic against a queue-based flag/checkpoint model.
module tb_execute_flag_ckpt_register;
  localparam int FW = 5, NS = 4, D = 4, CW = 3;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  execute_flag_ckpt_register_if #(.P_FLAG_W(FW), .P_NSRC(NS), .P_CKPT_DEPTH(D), .P_CNT_W(CW)) bus ();
  execute_flag_ckpt_register #(.P_FLAG_W(FW), .P_NSRC(NS), .P_CKPT_DEPTH(D), .P_CNT_W(CW)) dut (
    .iCLOCK(clk), .inRESET(rst_n), .bus(bus));
  int errors = 0, checks = 0;
  logic [FW-1:0] q[$];
  logic [FW-1:0] mflag = '0;
  logic movf = 1'b0;

  task automatic idle();
    bus.iRESET_SYNC = 0; bus.iCTRL_HOLD = 0; bus.iPFLAGR_VALID = 0; bus.iPFLAGR = '0;
    bus.iPREV_INST_VALID = 0; bus.iPREV_BUSY = 0; bus.iPREV_FLAG_WRITE = 0;
    bus.iSRC_VALID = '0; bus.iSRC_FLAG = '0;
    bus.iCKPT_PUSH = 0; bus.iCKPT_RELEASE = 0; bus.iCKPT_RESTORE = 0;
  endtask

  task automatic model_reset();
    mflag = '0; movf = 0; q.delete();
  endtask

  // advance the reference model from the current inputs, then clock the DUT
  task automatic tick();
    logic [FW-1:0] nf;
    bit found;
    if (bus.iRESET_SYNC) model_reset();
    else if (bus.iCKPT_RESTORE && q.size() > 0) begin
      mflag = q[0];
      q.delete();
    end else begin
      nf = mflag;
      found = 0;
      if (bus.iPFLAGR_VALID) nf = bus.iPFLAGR;
      else if (!bus.iCTRL_HOLD && bus.iPREV_INST_VALID && !bus.iPREV_BUSY && bus.iPREV_FLAG_WRITE)
        for (int i = 0; i < NS; i++)
          if (!found && bus.iSRC_VALID[i]) begin nf = bus.iSRC_FLAG[i*FW +: FW]; found = 1; end
      if (!bus.iCTRL_HOLD) begin
        if (bus.iCKPT_RELEASE && q.size() > 0) void'(q.pop_front());
        if (bus.iCKPT_PUSH) begin
          if (q.size() < D) q.push_back(nf);
          else movf = 1;
        end
      end
      mflag = nf;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_val(input logic [FW-1:0] v);
    idle(); bus.iPFLAGR_VALID = 1; bus.iPFLAGR = v; bus.iCKPT_PUSH = 1; tick();
  endtask

  task automatic test_reset();
    idle();
    #12;
    checks++; if (bus.oFLAG !== 5'h00) begin errors++; $display("FAIL reset_flag got %h exp 00", bus.oFLAG); end
    checks++; if (bus.oCKPT_COUNT !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.oCKPT_COUNT); end
    checks++; if (bus.oCKPT_OVF !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", bus.oCKPT_OVF); end
    checks++; if (bus.oCKPT_EMPTY !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", bus.oCKPT_EMPTY); end
    rst_n = 1;
  endtask

  task automatic test_priority();
    idle();
    bus.iPREV_INST_VALID = 1; bus.iPREV_FLAG_WRITE = 1;
    bus.iSRC_VALID = 4'b1100; bus.iSRC_FLAG = {5'h15, 5'h0A, 5'h00, 5'h00};
    tick();
    checks++; if (bus.oFLAG !== 5'h0A) begin errors++; $display("FAIL prio_src2 got %h exp 0a", bus.oFLAG); end
    bus.iPREV_BUSY = 1; bus.iSRC_FLAG = {5'h15, 5'h0B, 5'h00, 5'h00};
    tick();
    checks++; if (bus.oFLAG !== 5'h0A) begin errors++; $display("FAIL prio_busy_hold got %h exp 0a", bus.oFLAG); end
    bus.iPREV_BUSY = 0; bus.iSRC_VALID = 4'b1111; bus.iSRC_FLAG = {5'h01, 5'h02, 5'h03, 5'h04};
    tick();
    checks++; if (bus.oFLAG !== 5'h04) begin errors++; $display("FAIL prio_src0 got %h exp 04", bus.oFLAG); end
  endtask

  task automatic test_push_restore();
    idle(); bus.iPFLAGR_VALID = 1; bus.iPFLAGR = 5'h03; tick();
    checks++; if (bus.oFLAG !== 5'h03) begin errors++; $display("FAIL pflagr_write got %h exp 03", bus.oFLAG); end
    idle(); bus.iPREV_INST_VALID = 1; bus.iPREV_FLAG_WRITE = 1; bus.iSRC_VALID = 4'b0001;
    bus.iSRC_FLAG = {15'h0, 5'h11}; bus.iCKPT_PUSH = 1; tick();
    checks++; if (bus.oCKPT_COUNT !== 3'd1) begin errors++; $display("FAIL push_count got %0d exp 1", bus.oCKPT_COUNT); end
    idle(); bus.iPFLAGR_VALID = 1; bus.iPFLAGR = 5'h07; tick();
    idle(); bus.iCKPT_RESTORE = 1; tick();
    checks++; if (bus.oFLAG !== 5'h11) begin errors++; $display("FAIL restore_next_val got %h exp 11", bus.oFLAG); end
    checks++; if (bus.oCKPT_COUNT !== 3'd0) begin errors++; $display("FAIL restore_count got %0d exp 0", bus.oCKPT_COUNT); end
  endtask

  task automatic test_full_ovf_wrap();
    for (int i = 1; i <= 4; i++) push_val(FW'(i));
    checks++; if (bus.oCKPT_FULL !== 1'b1) begin errors++; $display("FAIL full got %b exp 1", bus.oCKPT_FULL); end
    push_val(5'h05);
    checks++; if (bus.oCKPT_OVF !== 1'b1) begin errors++; $display("FAIL ovf got %b exp 1", bus.oCKPT_OVF); end
    checks++; if (bus.oCKPT_COUNT !== 3'd4) begin errors++; $display("FAIL ovf_count got %0d exp 4", bus.oCKPT_COUNT); end
    idle(); bus.iCKPT_RELEASE = 1; tick(); tick();
    checks++; if (bus.oCKPT_COUNT !== 3'd2) begin errors++; $display("FAIL release_count got %0d exp 2", bus.oCKPT_COUNT); end
    push_val(5'h05); push_val(5'h06);
    idle(); bus.iCKPT_RESTORE = 1; tick();
    checks++; if (bus.oFLAG !== 5'h03) begin errors++; $display("FAIL wrap_restore got %h exp 03", bus.oFLAG); end
    checks++; if (bus.oCKPT_COUNT !== 3'd0) begin errors++; $display("FAIL wrap_count got %0d exp 0", bus.oCKPT_COUNT); end
    checks++; if (bus.oCKPT_OVF !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", bus.oCKPT_OVF); end
  endtask

  task automatic test_async_reset();
    for (int i = 1; i <= 4; i++) push_val(FW'(i));
    idle();
    #2 rst_n = 0;
    #1;
    checks++; if (bus.oFLAG !== 5'h00) begin errors++; $display("FAIL async_flag got %h exp 00", bus.oFLAG); end
    checks++; if (bus.oCKPT_COUNT !== 3'd0) begin errors++; $display("FAIL async_count got %0d exp 0", bus.oCKPT_COUNT); end
    checks++; if (bus.oCKPT_OVF !== 1'b0) begin errors++; $display("FAIL async_ovf got %b exp 0", bus.oCKPT_OVF); end
    model_reset();
    #1 rst_n = 1;
    bus.iRESET_SYNC = 1; bus.iPFLAGR_VALID = 1; bus.iPFLAGR = 5'h1F; tick();
    checks++; if (bus.oFLAG !== 5'h00) begin errors++; $display("FAIL sync_over_pflagr got %h exp 00", bus.oFLAG); end
  endtask

  task automatic test_hold();
    push_val(5'h09); push_val(5'h0C);
    idle(); bus.iCTRL_HOLD = 1; bus.iCKPT_PUSH = 1; bus.iCKPT_RELEASE = 1;
    bus.iPREV_INST_VALID = 1; bus.iPREV_FLAG_WRITE = 1; bus.iSRC_VALID = 4'b0001; bus.iSRC_FLAG = {15'h0, 5'h1F};
    tick();
    checks++; if (bus.oFLAG !== 5'h0C) begin errors++; $display("FAIL hold_flag got %h exp 0c", bus.oFLAG); end
    checks++; if (bus.oCKPT_COUNT !== 3'd2) begin errors++; $display("FAIL hold_count got %0d exp 2", bus.oCKPT_COUNT); end
    idle(); bus.iCTRL_HOLD = 1; bus.iCKPT_RESTORE = 1; tick();
    checks++; if (bus.oFLAG !== 5'h09) begin errors++; $display("FAIL hold_restore got %h exp 09", bus.oFLAG); end
    checks++; if (bus.oCKPT_COUNT !== 3'd0) begin errors++; $display("FAIL hold_restore_count got %0d exp 0", bus.oCKPT_COUNT); end
  endtask

  task automatic test_push_release_full();
    idle(); bus.iRESET_SYNC = 1; tick();
    for (int i = 1; i <= 4; i++) push_val(FW'(i));
    idle(); bus.iCKPT_PUSH = 1; bus.iCKPT_RELEASE = 1; tick();
    checks++; if (bus.oCKPT_COUNT !== 3'd4) begin errors++; $display("FAIL pr_full_count got %0d exp 4", bus.oCKPT_COUNT); end
    checks++; if (bus.oCKPT_OVF !== 1'b0) begin errors++; $display("FAIL pr_full_ovf got %b exp 0", bus.oCKPT_OVF); end
    idle(); bus.iCKPT_RESTORE = 1; tick();
    checks++; if (bus.oFLAG !== 5'h02) begin errors++; $display("FAIL pr_oldest got %h exp 02", bus.oFLAG); end
    idle(); bus.iCKPT_RELEASE = 1; tick();
    checks++; if (bus.oCKPT_COUNT !== 3'd0) begin errors++; $display("FAIL release_empty got %0d exp 0", bus.oCKPT_COUNT); end
    checks++; if (bus.oFLAG !== 5'h02) begin errors++; $display("FAIL release_empty_flag got %h exp 02", bus.oFLAG); end
    idle(); bus.iCKPT_PUSH = 1; bus.iCKPT_RELEASE = 1; tick();
    checks++; if (bus.oCKPT_COUNT !== 3'd1) begin errors++; $display("FAIL pr_empty got %0d exp 1", bus.oCKPT_COUNT); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      bus.iRESET_SYNC      = $urandom_range(0, 59) == 0;
      bus.iCKPT_RESTORE    = $urandom_range(0, 9) == 0;
      bus.iPFLAGR_VALID    = $urandom_range(0, 4) == 0;
      bus.iPFLAGR          = FW'($urandom);
      bus.iCTRL_HOLD       = $urandom_range(0, 5) == 0;
      bus.iPREV_INST_VALID = $urandom_range(0, 3) != 0;
      bus.iPREV_BUSY       = $urandom_range(0, 3) == 0;
      bus.iPREV_FLAG_WRITE = $urandom_range(0, 3) != 0;
      bus.iSRC_VALID       = NS'($urandom);
      bus.iSRC_FLAG        = (NS*FW)'($urandom);
      bus.iCKPT_PUSH       = $urandom_range(0, 1) == 0;
      bus.iCKPT_RELEASE    = $urandom_range(0, 2) == 0;
      tick();
      checks++; if (bus.oFLAG !== mflag) begin errors++; $display("FAIL rnd_flag cyc %0d got %h exp %h", n, bus.oFLAG, mflag); end
      checks++; if (bus.oCKPT_COUNT !== CW'(q.size())) begin errors++; $display("FAIL rnd_count cyc %0d got %0d exp %0d", n, bus.oCKPT_COUNT, q.size()); end
      checks++; if (bus.oCKPT_FULL !== (q.size() == D)) begin errors++; $display("FAIL rnd_full cyc %0d got %b", n, bus.oCKPT_FULL); end
      checks++; if (bus.oCKPT_EMPTY !== (q.size() == 0)) begin errors++; $display("FAIL rnd_empty cyc %0d got %b", n, bus.oCKPT_EMPTY); end
      checks++; if (bus.oCKPT_OVF !== movf) begin errors++; $display("FAIL rnd_ovf cyc %0d got %b exp %b", n, bus.oCKPT_OVF, movf); end
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_push_restore();
    test_full_ovf_wrap();
    test_async_reset();
    test_hold();
    test_push_release_full();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/execute_flag_ckpt_register.md
Name: execute_flag_ckpt_register

Overview:
- Parametrised next-generation execute-stage flag register with a configurable flag width and a configurable number of priority-ordered result sources.
- Adds an in-order checkpoint FIFO so that flags can be restored after a branch mispredict.
- Sits in the execute stage. Fed by the ALU result units and by the branch unit (checkpoint push, release and restore).
- oFLAG drives the conditional-execute and branch logic.

Parameters:
- P_FLAG_W, 5, flag vector width.
- P_NSRC, 4, number of flag-producing result sources. Source 0 has the highest priority.
- P_CKPT_DEPTH, 4, number of checkpoint FIFO entries (>=1).
- P_CNT_W, $clog2(P_CKPT_DEPTH+1), width of the checkpoint count.

Ports:
- iCLOCK  in  1  clock, rising edge.
- inRESET  in  1  asynchronous active-low reset.
- iRESET_SYNC  in  1  synchronous clear.
- iCTRL_HOLD  in  1  pipeline hold.
- iPFLAGR_VALID  in  1  direct flag-register write.
- iPFLAGR  in  P_FLAG_W  direct write data.
- iPREV_INST_VALID  in  1  previous-stage instruction valid.
- iPREV_BUSY  in  1  previous stage busy.
- iPREV_FLAG_WRITE  in  1  instruction writes flags.
- iSRC_VALID  in  P_NSRC  per-source result valid.
- iSRC_FLAG  in  P_NSRC*P_FLAG_W  per-source flags. Source i occupies bits [i*P_FLAG_W +: P_FLAG_W].
- iCKPT_PUSH  in  1  branch issued; capture a checkpoint.
- iCKPT_RELEASE  in  1  oldest branch resolved correctly; drop the oldest checkpoint.
- iCKPT_RESTORE  in  1  oldest branch mispredicted; restore flags and flush the FIFO.
- oFLAG  out  P_FLAG_W  current flags.
- oCKPT_COUNT  out  P_CNT_W  number of valid checkpoints.
- oCKPT_FULL  out  1  oCKPT_COUNT == P_CKPT_DEPTH.
- oCKPT_EMPTY  out  1  oCKPT_COUNT == 0.
- oCKPT_OVF  out  1  sticky: a push was dropped while the FIFO was full.

Behaviour:
- Clock and reset: one clock, iCLOCK. Reset inRESET is asynchronous and active-low.
- Reset values:
  - inRESET low: oFLAG=0, count=0, read/write pointers=0, oCKPT_OVF=0, all FIFO entries=0.
  - iRESET_SYNC high: same values, applied at the next edge.
- Update priority per edge: inRESET > iRESET_SYNC > iCKPT_RESTORE > iPFLAGR_VALID > iCTRL_HOLD > normal update.
- Restore, when count>0:
  - flags <= oldest entry; FIFO flushed (count=0, wptr=rptr).
  - A push or release in the same cycle is ignored.
  - Overrides iCTRL_HOLD and iPFLAGR_VALID.
- Restore when count==0: ignored. No flag or FIFO change; lower-priority actions proceed normally.
- iPFLAGR_VALID: flags <= iPFLAGR.
- iCTRL_HOLD: flags hold, and push/release are suppressed (FIFO frozen).
- Normal update:
  - Requires iPREV_INST_VALID && !iPREV_BUSY && iPREV_FLAG_WRITE.
  - flags <= iSRC_FLAG of the lowest-index source with iSRC_VALID set.
  - No valid source: flags hold.
- Push (not held, no effective restore):
  - Captures the NEXT value of the flags, i.e. post-update this cycle (including a same-cycle iPFLAGR write). Latency 0.
  - Written at wptr; wptr increments modulo P_CKPT_DEPTH.
- Release (not held, no effective restore): rptr increments modulo P_CKPT_DEPTH. Ignored when count==0.
- Push and release in the same cycle:
  - Both execute and count is unchanged. Legal when full.
  - When empty: push executes, release is ignored, count becomes 1.
- Push when full without a release: dropped; oCKPT_OVF <= 1. oCKPT_OVF is cleared only by reset.
- Pointer wrap-around must preserve FIFO order for any P_CKPT_DEPTH, including non-powers of 2.
- Outputs: oFLAG, count, full and empty are registered or derived from registers only. There is no combinational path from the inputs.

Optional Feature:
- Macro: EXECUTE_FLAG_CKPT_SRC_CHECK_EN.
- Defined:
  - Adds output oSRC_CONFLICT (1 bit, registered, reset 0).
  - Pulses high for one cycle, at the edge after a normal update in which more than one iSRC_VALID bit was set.
  - The priority choice is still applied.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset and priority: assert inRESET mid-cycle while FULL -> oFLAG=0, count=0 and oCKPT_OVF=0 immediately. Then iRESET_SYNC=1 together with iPFLAGR_VALID=1, iPFLAGR=5'h1F -> oFLAG stays 0.
- Source priority (P_NSRC=4): valid update with iSRC_VALID=4'b1100, src2=5'h0A, src3=5'h15 -> oFLAG=5'h0A. iPREV_BUSY=1 with the same inputs -> oFLAG holds.
- Push captures next value: oFLAG=5'h03; one cycle with update src0=5'h11 and iCKPT_PUSH=1 -> count=1. Later, with oFLAG=5'h07, iCKPT_RESTORE=1 -> oFLAG=5'h11, count=0.
- Full, overflow and wrap: 4 pushes with flags 1,2,3,4 -> FULL. 5th push -> dropped, OVF=1. Release twice, push 5 and 6, restore -> oFLAG=3 (oldest entry); count=0.
- Hold interaction: iCTRL_HOLD=1 with push, release and an update -> no change. iCTRL_HOLD=1 with restore (count=2, oldest=5'h09) -> oFLAG=5'h09.
- Simultaneous push and release at FULL -> count stays 4 and OVF stays 0. Release with count=0 -> no change.
